// File: rtl/wfg_timer_pkg.sv
// Shared definitions for the wfg timer: register word offsets, CTRL bit
// positions and the CTRL register layout.
package wfg_timer_pkg;

  localparam logic [2:0] CTRL_OFF   = 3'h0;
  localparam logic [2:0] PRESC_OFF  = 3'h1;
  localparam logic [2:0] CMP_OFF    = 3'h2;
  localparam logic [2:0] CNT_OFF    = 3'h3;
  localparam logic [2:0] STATUS_OFF = 3'h4;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_PERIODIC_BIT = 2;

  // Field order makes bit 0 EN, bit 1 IRQ_EN, bit 2 PERIODIC.
  typedef struct packed {
    logic periodic;
    logic irq_en;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {29'b0, c};
  endfunction

endpackage

// File: rtl/wfg_timer_core.sv
// Prescaled up-counter with compare match and sticky MATCH flag.
// EN lives in the register file; a one-shot match asks it to drop via oneshot_stop_o.
module wfg_timer_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   periodic_i,
  input  logic                   pc_clr_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic [CNT_WIDTH-1:0]   cmp_i,
  input  logic                   cnt_we_i,
  input  logic [CNT_WIDTH-1:0]   cnt_wdata_i,
  input  logic                   match_clr_i,
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic                   match_o,
  output logic                   oneshot_stop_o
);

  logic [PRESC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   match_q, match_d;
  logic                   tick;
  logic                   hit;

  always_comb begin
    tick = en_i && (pc_q == presc_i);
    hit  = tick && (cnt_q == cmp_i);

    pc_d = pc_q;
    if (pc_clr_i) begin
      pc_d = '0;
    end else if (en_i) begin
      pc_d = tick ? '0 : pc_q + PRESC_WIDTH'(1);
    end

    // A bus write to CNT overrides the tick's increment.
    cnt_d = cnt_q;
    if (cnt_we_i) begin
      cnt_d = cnt_wdata_i;
    end else if (tick) begin
      cnt_d = hit ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    // Setting beats a simultaneous write-1-to-clear.
    match_d = match_q;
    if (hit) begin
      match_d = 1'b1;
    end else if (match_clr_i) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign match_o        = match_q;
  assign oneshot_stop_o = hit && !periodic_i;

endmodule

// File: rtl/wfg_timer.sv
// Wishbone-slave programmable timer: register file, read mux and level
// interrupt around the wfg_timer_core counter.
module wfg_timer
  import wfg_timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        interrupt_o
);

  ctrl_t                  ctrl_q, ctrl_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [CNT_WIDTH-1:0]   cmp_q, cmp_d;
  logic                   ack_q;
  logic [31:0]            dat_q, dat_d;
  logic                   irq_q;

  logic                   req;
  logic                   wr;
  logic [2:0]             sel;
  logic [31:0]            rdata;
  logic                   pc_clr;
  logic                   cnt_we;
  logic                   match_clr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   match;
  logic                   oneshot_stop;

  logic                   unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  // Handshake: a request is stb & cyc while ack is low. It is acknowledged by a
  // one-cycle ack pulse on the next edge; that edge also commits the write and
  // registers the read data, so a held request is served every second cycle.
  assign req = wbs_stb_i && wbs_cyc_i && !ack_q;
  assign wr  = req && wbs_we_i;
  assign sel = wbs_adr_i[4:2];

  assign pc_clr    = wr && (sel == CTRL_OFF) && wbs_dat_i[CTRL_EN_BIT] && !ctrl_q.en;
  assign cnt_we    = wr && (sel == CNT_OFF);
  assign match_clr = wr && (sel == STATUS_OFF) && wbs_dat_i[0];

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    if (oneshot_stop) begin
      ctrl_d.en = 1'b0;
    end
    if (wr) begin
      case (sel)
        CTRL_OFF: begin
          ctrl_d.en       = wbs_dat_i[CTRL_EN_BIT];
          ctrl_d.irq_en   = wbs_dat_i[CTRL_IRQ_EN_BIT];
          ctrl_d.periodic = wbs_dat_i[CTRL_PERIODIC_BIT];
        end
        PRESC_OFF: presc_d = wbs_dat_i[PRESC_WIDTH-1:0];
        CMP_OFF:   cmp_d   = wbs_dat_i[CNT_WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      CTRL_OFF:   rdata = ctrl_to_word(ctrl_q);
      PRESC_OFF:  rdata[PRESC_WIDTH-1:0] = presc_q;
      CMP_OFF:    rdata[CNT_WIDTH-1:0]   = cmp_q;
      CNT_OFF:    rdata[CNT_WIDTH-1:0]   = cnt;
      STATUS_OFF: rdata[0] = match;
      default:    rdata = '0;
    endcase
    dat_d = req ? rdata : dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      ack_q   <= req;
      dat_q   <= dat_d;
      irq_q   <= match && ctrl_q.irq_en;
    end
  end

  wfg_timer_core #(
    .CNT_WIDTH  (CNT_WIDTH),
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .en_i          (ctrl_q.en),
    .periodic_i    (ctrl_q.periodic),
    .pc_clr_i      (pc_clr),
    .presc_i       (presc_q),
    .cmp_i         (cmp_q),
    .cnt_we_i      (cnt_we),
    .cnt_wdata_i   (wbs_dat_i[CNT_WIDTH-1:0]),
    .match_clr_i   (match_clr),
    .cnt_o         (cnt),
    .match_o       (match),
    .oneshot_stop_o(oneshot_stop)
  );

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign interrupt_o = irq_q;

endmodule

// File: tb/tb_wfg_timer.sv
// Bench for wfg_timer: directed register/timing steps plus randomized
// configurations checked against an arithmetic timer model.
module tb_wfg_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] dat_i = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_ack = 0;

  // Model of the active configuration, referenced to the edge that enabled it
  int unsigned m_start, m_p, m_c;
  bit          m_per, m_irq, m_match0;
  int          m_ref;

  wfg_timer dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_dat_i  (dat_i),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .interrupt_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Timer state after n clock edges since the reference edge.
  function automatic void model(input int n, output logic [31:0] cnt,
                                output bit matched, output bit en);
    int unsigned nn, ticks, first;
    nn = (n < 0) ? 0 : n;
    ticks = nn / (m_p + 1);
    matched = m_match0;
    en = 1'b1;
    if (m_start > m_c) begin
      cnt = 32'(m_start + ticks);
    end else begin
      first = m_c - m_start + 1;
      if (ticks < first) begin
        cnt = 32'(m_start + ticks);
      end else begin
        matched = 1'b1;
        if (m_per) begin
          cnt = 32'((ticks - first) % (m_c + 1));
        end else begin
          cnt = '0;
          en = 1'b0;
        end
      end
    end
  endfunction

  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] r);
    int lat;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 8);
    chk("ack_latency", 32'(lat), 32'd1);
    r = dat_o;
    last_ack = edge_n;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    wb(1'b0, a, 32'h0, r);
  endtask

  task automatic wait_until(input int t);
    while (edge_n < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic configure(input int unsigned p, input int unsigned c, input int unsigned s,
                           input bit per, input bit ie);
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h0C, s);
    wr(32'h04, p);
    wr(32'h08, c);
    m_p = p; m_c = c; m_start = s; m_per = per; m_irq = ie; m_match0 = 1'b0;
    wr(32'h00, {29'b0, per, ie, 1'b1});
    m_ref = last_ack;
  endtask

  task automatic check_reg(input int idx, input string tag);
    logic [31:0] r, cnt, exp;
    bit m, en;
    rd(32'(idx * 4), r);
    model(last_ack - 1 - m_ref, cnt, m, en);
    case (idx)
      0:       exp = {29'b0, m_per, m_irq, en};
      1:       exp = m_p;
      2:       exp = m_c;
      3:       exp = cnt;
      default: exp = {31'b0, m};
    endcase
    chk(tag, r, exp);
    model(last_ack - m_ref, cnt, m, en);
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, m_irq & m});
  endtask

  task automatic check_irq_edges(input int k);
    logic [31:0] cnt;
    bit m, en;
    for (int i = 0; i < k; i++) begin
      model(edge_n - 1 - m_ref, cnt, m, en);
      chk("irq_edge", {31'b0, irq}, {31'b0, m_irq & m});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int unsigned p, c, s;
    bit per, ie;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd(32'(a * 4), r);
      chk("reset_read", r, 32'd0);
      chk("reset_irq", {31'b0, irq}, 32'd0);
    end

    // Prescaler 3: count advances every 4 clocks
    configure(3, 32'hFFFF, 0, 1'b0, 1'b0);
    wait_until(m_ref + 23);
    rd(32'h0C, r);
    chk("cnt_presc3", r, 32'd5);
    chk("cnt_presc3_edge", 32'(last_ack - m_ref), 32'd24);
    check_reg(3, "cnt_presc3_model");

    // Periodic with interrupt, P=0, C=4
    configure(0, 4, 0, 1'b1, 1'b1);
    check_irq_edges(10);
    for (int i = 0; i < 6; i++) check_reg(3, "periodic_cnt");
    check_reg(4, "periodic_status");
    check_reg(0, "periodic_ctrl");

    // STATUS write of 0 leaves MATCH set; CNT write while counting
    wr(32'h10, 32'h0);
    check_reg(4, "status_w0");
    wr(32'h0C, 32'h10);
    m_start = 32'h10; m_ref = last_ack; m_match0 = 1'b1;
    for (int i = 0; i < 3; i++) check_reg(3, "cnt_load");
    check_reg(4, "cnt_load_status");

    // One-shot with interrupt, C=2
    configure(0, 2, 0, 1'b0, 1'b1);
    check_irq_edges(8);
    check_reg(0, "oneshot_ctrl");
    check_reg(3, "oneshot_cnt");
    check_reg(4, "oneshot_status");
    chk("oneshot_irq_held", {31'b0, irq}, 32'd1);
    wr(32'h10, 32'h1);
    chk("oneshot_irq_clr", {31'b0, irq}, 32'd0);
    rd(32'h10, r);
    chk("oneshot_status_clr", r, 32'd0);

    // Unmapped offsets
    rd(32'h18, r);
    chk("unmapped_rd", r, 32'd0);
    wr(32'h18, 32'hFFFF_FFFF);
    rd(32'h00, r); chk("unmapped_ctrl", r, 32'h2);
    rd(32'h04, r); chk("unmapped_presc", r, 32'h0);
    rd(32'h08, r); chk("unmapped_cmp", r, 32'h2);
    rd(32'h0C, r); chk("unmapped_cnt", r, 32'h0);
    rd(32'h10, r); chk("unmapped_status", r, 32'h0);
    rd(32'h14, r); chk("unmapped_14", r, 32'h0);
    rd(32'h1C, r); chk("unmapped_1c", r, 32'h0);

    // Randomized configurations
    for (int it = 0; it < 10; it++) begin
      p = $urandom_range(0, 3);
      c = $urandom_range(0, 6);
      s = $urandom_range(0, c);
      per = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      configure(p, c, s, per, ie);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1;
        case ($urandom_range(0, 2))
          0:       check_reg(3, "rand_cnt");
          1:       check_reg(4, "rand_status");
          default: check_reg(0, "rand_ctrl");
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
